// File: rtl/dcls_bist_scheduler.sv
// dcls_bist_scheduler
// Sequences a dual-core lockstep comparator: enables it, periodically runs a
// fault-injection self-test of TEST_LEN cycles, checks that every injected
// (tagged) cycle was flagged, and counts untagged (real) comparator errors.
// Optional feature: define DCLS_BIST_SCHED_PAIR_CHECK_EN to enable the
// ERR_DCLS / ERR_DCLS_B complement check driving PAIR_FAULT.
module dcls_bist_scheduler #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_OR_STAGES = 0,
  parameter int PERIOD_W      = 16,
  parameter int CNT_W         = 8
) (
  input  logic                CLK,
  input  logic                RESETN,
  input  logic                CFG_ENABLE,
  input  logic [PERIOD_W-1:0] CFG_PERIOD,
  input  logic                START_REQ,
  input  logic                FAIL_CLR,
  input  logic                ERR_DCLS,
  input  logic                ERR_DCLS_B,
  input  logic                IS_FIERR_OUT,
  output logic                ENERR_DCLS,
  output logic                FIERR_DCLS,
  output logic                BIST_BUSY,
  output logic                BIST_DONE,
  output logic                BIST_FAIL,
  output logic                PAIR_FAULT,
  output logic                REAL_ERR,
  output logic [CNT_W-1:0]    REAL_ERR_CNT
);

  localparam int TEST_LEN = 2 * DATA_WIDTH;
  localparam int LAT      = NUM_OR_STAGES + 2;
  localparam int HIT_W    = $clog2(TEST_LEN + 1);
  localparam int SEQ_W    = $clog2(TEST_LEN + LAT + 2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_NORMAL = 3'd2,
    ST_TEST   = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                init_q, init_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic                pend_q, pend_d;
  logic [HIT_W-1:0]    hit_q, hit_d;
  logic                miss_q, miss_d;
  logic                enerr_q, enerr_d;
  logic                fierr_q, fierr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic                pair_q, pair_d;
  logic                rerr_q, rerr_d;
  logic [CNT_W-1:0]    rcnt_q, rcnt_d;

  logic                tag_s;
  logic                active_s;
  logic                enter_test_s;
  logic                fail_set_s;
  logic [HIT_W-1:0]    hit_next_s;
  logic                miss_next_s;

  // Self-test evidence for the current cycle: tagged hits and tagged misses.
  always_comb begin
    tag_s       = 1'b0;
    hit_next_s  = hit_q;
    miss_next_s = miss_q;
    if ((state_q == ST_TEST) || (state_q == ST_DRAIN)) begin
      tag_s = IS_FIERR_OUT;
    end else begin
      tag_s = 1'b0;
    end
    if (tag_s && ERR_DCLS && (hit_q != {HIT_W{1'b1}})) begin
      hit_next_s = hit_q + HIT_W'(1);
    end else begin
      hit_next_s = hit_q;
    end
    miss_next_s = miss_q | (tag_s & ~ERR_DCLS);
  end

  // Sequencer: next state, phase counter, period counter and pending request.
  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    per_d      = per_q;
    pend_d     = pend_q;
    done_d     = 1'b0;
    fail_set_s = 1'b0;
    init_d     = 1'b1;
    if (!CFG_ENABLE) begin
      // Disabling abandons any test silently; sticky results are untouched.
      state_d = ST_IDLE;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          pend_d = 1'b0;
          // init_q holds IDLE for the first cycle after reset release.
          if (init_q) begin
            state_d = ST_ARM;
            seq_d   = SEQ_W'(LAT - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARM: begin
          if (seq_q == SEQ_W'(0)) begin
            state_d = ST_NORMAL;
            per_d   = CFG_PERIOD;
          end else begin
            seq_d = seq_q - SEQ_W'(1);
          end
        end
        ST_NORMAL: begin
          // A zero period never self-triggers; only requests start a test.
          if (START_REQ || pend_q || (per_q == PERIOD_W'(1))) begin
            state_d = ST_TEST;
            seq_d   = SEQ_W'(TEST_LEN - 1);
            pend_d  = 1'b0;
          end else if (per_q != PERIOD_W'(0)) begin
            per_d = per_q - PERIOD_W'(1);
          end else begin
            per_d = per_q;
          end
        end
        ST_TEST: begin
          pend_d = pend_q | START_REQ;
          if (seq_q == SEQ_W'(0)) begin
            state_d = ST_DRAIN;
            seq_d   = SEQ_W'(LAT);
          end else begin
            seq_d = seq_q - SEQ_W'(1);
          end
        end
        ST_DRAIN: begin
          pend_d = pend_q | START_REQ;
          if (seq_q == SEQ_W'(0)) begin
            state_d    = ST_NORMAL;
            per_d      = CFG_PERIOD;
            done_d     = 1'b1;
            fail_set_s = (hit_next_s != HIT_W'(TEST_LEN)) | miss_next_s;
          end else begin
            seq_d = seq_q - SEQ_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

  // Registered outputs, evidence counters, real-error and sticky flag updates.
  always_comb begin
    enter_test_s = (state_q != ST_TEST) && (state_d == ST_TEST);
    enerr_d      = (state_d != ST_IDLE);
    fierr_d      = (state_d == ST_TEST);
    busy_d       = (state_d == ST_TEST) || (state_d == ST_DRAIN);
    active_s     = (state_q == ST_NORMAL) || (state_q == ST_TEST) || (state_q == ST_DRAIN);
    rerr_d       = ERR_DCLS & ~IS_FIERR_OUT & active_s;
    if (enter_test_s) begin
      hit_d  = {HIT_W{1'b0}};
      miss_d = 1'b0;
    end else begin
      hit_d  = hit_next_s;
      miss_d = miss_next_s;
    end
    // An error event in the same cycle as FAIL_CLR takes precedence.
    if (rerr_d) begin
      if (rcnt_q != {CNT_W{1'b1}}) begin
        rcnt_d = rcnt_q + CNT_W'(1);
      end else begin
        rcnt_d = rcnt_q;
      end
    end else if (FAIL_CLR) begin
      rcnt_d = {CNT_W{1'b0}};
    end else begin
      rcnt_d = rcnt_q;
    end
    if (fail_set_s) begin
      fail_d = 1'b1;
    end else if (FAIL_CLR) begin
      fail_d = 1'b0;
    end else begin
      fail_d = fail_q;
    end
  end

`ifdef DCLS_BIST_SCHED_PAIR_CHECK_EN
  logic pair_set_s;

  // ERR and ERR_B must always be complements once the comparator is enabled.
  always_comb begin
    pair_set_s = (state_q != ST_IDLE) && (ERR_DCLS == ERR_DCLS_B);
    if (pair_set_s) begin
      pair_d = 1'b1;
    end else if (FAIL_CLR) begin
      pair_d = 1'b0;
    end else begin
      pair_d = pair_q;
    end
  end
`else
  logic unused_err_b_s;
  assign unused_err_b_s = ERR_DCLS_B;

  // Pair check not built: the flag never sets.
  always_comb begin
    pair_d = 1'b0;
  end
`endif

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      init_q  <= 1'b0;
      seq_q   <= {SEQ_W{1'b0}};
      per_q   <= {PERIOD_W{1'b0}};
      pend_q  <= 1'b0;
      hit_q   <= {HIT_W{1'b0}};
      miss_q  <= 1'b0;
      enerr_q <= 1'b0;
      fierr_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      pair_q  <= 1'b0;
      rerr_q  <= 1'b0;
      rcnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      seq_q   <= seq_d;
      per_q   <= per_d;
      pend_q  <= pend_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      enerr_q <= enerr_d;
      fierr_q <= fierr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      pair_q  <= pair_d;
      rerr_q  <= rerr_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign ENERR_DCLS   = enerr_q;
  assign FIERR_DCLS   = fierr_q;
  assign BIST_BUSY    = busy_q;
  assign BIST_DONE    = done_q;
  assign BIST_FAIL    = fail_q;
  assign PAIR_FAULT   = pair_q;
  assign REAL_ERR     = rerr_q;
  assign REAL_ERR_CNT = rcnt_q;

endmodule

// File: doc/dcls_bist_scheduler.md
DCLS_BIST_SCHEDULER -- requirements
Module: dcls_bist_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data width of the sequenced comparator; test length TEST_LEN = 2*DATA_WIDTH cycles.
REQ-002 Parameter NUM_OR_STAGES, default 0: comparator OR-pipeline depth; result latency LAT = NUM_OR_STAGES+2.
REQ-003 Parameter PERIOD_W, default 16: width of CFG_PERIOD.
REQ-004 Parameter CNT_W, default 8: width of REAL_ERR_CNT.
REQ-005 CLK  in  1  single clock, all state on rising edge.
REQ-006 RESETN  in  1  reset, asynchronous, active-low.
REQ-007 CFG_ENABLE  in  1  enable comparator sequencing.
REQ-008 CFG_PERIOD  in  PERIOD_W  cycles in NORMAL between self-tests; 0 = manual only.
REQ-009 START_REQ  in  1  single-cycle software request for a self-test.
REQ-010 FAIL_CLR  in  1  clears BIST_FAIL, PAIR_FAULT, REAL_ERR_CNT.
REQ-011 ERR_DCLS, ERR_DCLS_B, IS_FIERR_OUT  in  1 each  comparator result, complement, test tag.
REQ-012 ENERR_DCLS, FIERR_DCLS  out  1 each  comparator enable and fault-injection request (registered).
REQ-013 BIST_BUSY  out  1  high in TEST and DRAIN; BIST_DONE  out  1  one-cycle pulse at test end.
REQ-014 BIST_FAIL  out  1  sticky self-test failure; PAIR_FAULT  out  1  sticky ERR/ERR_B disagreement.
REQ-015 REAL_ERR  out  1  one-cycle pulse per untagged error; REAL_ERR_CNT  out  CNT_W  saturating count.

Function
REQ-016 FSM states SHALL be IDLE, ARM, NORMAL, TEST, DRAIN; ENERR_DCLS=1 in all states but IDLE; FIERR_DCLS=1 only in TEST.
REQ-017 IDLE->ARM when CFG_ENABLE=1; ARM lasts exactly LAT cycles then ->NORMAL (pipeline warm-up).
REQ-018 NORMAL loads period counter with CFG_PERIOD on entry; ->TEST after exactly CFG_PERIOD cycles, or on the cycle after START_REQ/pending request, whichever first.
REQ-019 CFG_PERIOD=0: NORMAL SHALL never self-trigger; only START_REQ starts a test.
REQ-020 TEST lasts exactly TEST_LEN cycles, then ->DRAIN; DRAIN lasts LAT+1 cycles, then ->NORMAL with BIST_DONE pulsed and period reloaded.
REQ-021 Tagged cycle = IS_FIERR_OUT=1 in TEST or DRAIN; hit counter (width clog2(TEST_LEN+1)) cleared on TEST entry, incremented per tagged cycle with ERR_DCLS=1.
REQ-022 At DRAIN exit, BIST_FAIL SHALL set if hit count != TEST_LEN or any tagged cycle had ERR_DCLS=0.
REQ-023 ERR_DCLS=1 with IS_FIERR_OUT=0 in ARM-complete NORMAL, TEST or DRAIN SHALL pulse REAL_ERR next cycle and increment REAL_ERR_CNT, saturating at all-ones.
REQ-024 START_REQ in TEST or DRAIN SHALL set one pending flag, serviced on return to NORMAL; further requests while pending are merged; START_REQ in IDLE/ARM ignored.
REQ-025 CFG_ENABLE=0 in any state SHALL go to IDLE next cycle, drop ENERR/FIERR, clear pending, no BIST_DONE, sticky flags unchanged.
REQ-026 FAIL_CLR and a same-cycle set of any sticky flag or count increment: set/increment wins.

Reset
REQ-027 RESETN low SHALL asynchronously force IDLE, ENERR_DCLS=0, FIERR_DCLS=0, BIST_BUSY=0, BIST_DONE=0, BIST_FAIL=0, PAIR_FAULT=0, REAL_ERR=0, REAL_ERR_CNT=0, counters and pending flag 0.
REQ-028 After RESETN release the block SHALL stay in IDLE at least one cycle before evaluating CFG_ENABLE.

Configuration
REQ-029 Macro DCLS_BIST_SCHED_PAIR_CHECK_EN defined: PAIR_FAULT sets when ERR_DCLS == ERR_DCLS_B in any cycle outside IDLE.
REQ-030 Macro undefined: pair-check logic absent, PAIR_FAULT tied 0; all other behaviour identical.

Verification (DATA_WIDTH=32, NUM_OR_STAGES=0: TEST_LEN=64, LAT=2)
REQ-031 CFG_ENABLE=1, CFG_PERIOD=100, healthy comparator -> ENERR rises 1 cycle later, FIERR high 64 cycles starting 102 cycles after ARM entry, BIST_DONE 3 cycles after FIERR falls, BIST_FAIL=0.
REQ-032 Comparator stuck ERR_DCLS=0 during test -> BIST_FAIL=1 at BIST_DONE, persists until FAIL_CLR.
REQ-033 CFG_PERIOD=0, START_REQ at cycle 10 of NORMAL and again mid-TEST -> one immediate test, exactly one follow-up test after DRAIN.
REQ-034 ERR_DCLS=1 with IS_FIERR_OUT=0 for 300 cycles, CNT_W=8 -> REAL_ERR pulses each cycle, REAL_ERR_CNT saturates at 255.
REQ-035 CFG_ENABLE dropped at TEST cycle 20 -> IDLE, FIERR/ENERR=0 next cycle, no BIST_DONE; RESETN low mid-TEST -> all outputs to reset values immediately.
REQ-036 With macro defined, force ERR_DCLS=ERR_DCLS_B=1 one cycle -> PAIR_FAULT=1 sticky; without macro -> PAIR_FAULT stays 0.
